arcade_input_cond: RTL and testbench

Input conditioner between the joystick source mux (USB / DB9MD / DB15 select) and the game core's control inputs. It takes the 8-bit packed control word `{coin, start2, start1, fire, up, down, left, right}` and produces three things:
- debounced direction, fire and start bits;
- a coin signal of fixed width and minimum gap, as the original coin mechanism would present;
- optionally, autofire on the fire bit.

It runs entirely in `clk_sys` with a tick prescaler, so debounce and pulse widths are independent of core clock enables.

---
 rtl/arcade_input_cond.sv | 207 ++++++++++++++++++++
 tb/tb_arcade_input_cond.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/arcade_input_cond.sv
// arcade_input_cond: conditions the packed joystick word
// {coin, start2, start1, fire, up, down, left, right} from the source mux.
// Each bit is synchronised and debounced on a shared millisecond-scale tick.
// The coin bit is reshaped into fixed-width credit pulses with a minimum gap,
// and at most one extra credit can be queued.
// Optional autofire on the fire bit is enabled by defining INPUT_COND_AUTOFIRE_EN.

// Per-bit debouncer: stb follows din only after DEB_LEN mismatching ticks.
module arcade_input_cond_deb #(
    parameter int DEB_LEN = 8
) (
    input  logic clk_sys,
    input  logic reset,
    input  logic tick,
    input  logic din,
    output logic stb
);
    logic [7:0] cnt;
    logic [7:0] cnt_inc;

    assign cnt_inc = cnt + 8'd1;

    // Any return to the stable value restarts the count, even between ticks.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            cnt <= 8'd0;
            stb <= 1'b0;
        end else if (din == stb) begin
            cnt <= 8'd0;
        end else if (tick) begin
            if (cnt_inc == 8'(DEB_LEN)) begin
                stb <= din;
                cnt <= 8'd0;
            end else begin
                cnt <= cnt_inc;
            end
        end
    end
endmodule

module arcade_input_cond #(
    parameter int TICK_DIV = 12000,
    parameter int DEB_LEN  = 8,
    parameter int COIN_HI  = 6,
    parameter int COIN_LO  = 6,
    parameter int AF_HALF  = 4
) (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic [7:0] joy_in,
    output logic [7:0] joy_out,
    output logic       credit_busy
);
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [1:0] {C_IDLE, C_HIGH, C_GAP} coin_state_t;

    logic [PW-1:0] pre_cnt;
    logic          tick;
    logic [7:0]    sync_a, sync_b;
    logic [7:0]    stb;
    logic          stb7_q;
    logic          coin_ev;
    logic          coin_out;
    coin_state_t   state, state_n;
    logic [7:0]    ccnt, ccnt_n, ccnt_inc;
    logic          pending, pending_n;

    assign tick = (pre_cnt == PW'(TICK_DIV - 1));

    // Free-running prescaler producing a one-cycle tick every TICK_DIV cycles.
    always_ff @(posedge clk_sys) begin
        if (reset)     pre_cnt <= '0;
        else if (tick) pre_cnt <= '0;
        else           pre_cnt <= pre_cnt + 1'b1;
    end

    // Two-flop synchroniser for the asynchronous control word.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            sync_a <= 8'd0;
            sync_b <= 8'd0;
        end else begin
            sync_a <= joy_in;
            sync_b <= sync_a;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_bit
            arcade_input_cond_deb #(.DEB_LEN(DEB_LEN)) u_deb (
                .clk_sys (clk_sys),
                .reset   (reset),
                .tick    (tick),
                .din     (sync_b[gi]),
                .stb     (stb[gi])
            );
        end
    endgenerate

    // Coin FSM registers, plus previous stb[7] for edge detection.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state   <= C_IDLE;
            ccnt    <= 8'd0;
            pending <= 1'b0;
            stb7_q  <= 1'b0;
        end else begin
            state   <= state_n;
            ccnt    <= ccnt_n;
            pending <= pending_n;
            stb7_q  <= stb[7];
        end
    end

    assign coin_ev  = stb[7] & ~stb7_q;
    assign ccnt_inc = ccnt + 8'd1;

    // Coin next-state: HIGH for COIN_HI ticks, GAP for COIN_LO ticks, one queued credit.
    always_comb begin
        state_n   = state;
        ccnt_n    = ccnt;
        pending_n = pending;
        coin_out  = 1'b0;
        case (state)
            C_IDLE: begin
                if (coin_ev) begin
                    state_n = C_HIGH;
                    ccnt_n  = 8'd0;
                end
            end
            C_HIGH: begin
                coin_out = 1'b1;
                if (coin_ev) pending_n = 1'b1;
                if (tick) begin
                    if (ccnt_inc == 8'(COIN_HI)) begin
                        state_n = C_GAP;
                        ccnt_n  = 8'd0;
                    end else begin
                        ccnt_n = ccnt_inc;
                    end
                end
            end
            C_GAP: begin
                if (tick && (ccnt_inc == 8'(COIN_LO))) begin
                    ccnt_n = 8'd0;
                    // A queued credit wins; an edge arriving while one is queued is dropped.
                    if (pending) begin
                        pending_n = 1'b0;
                        state_n   = C_HIGH;
                    end else if (coin_ev) begin
                        state_n = C_HIGH;
                    end else begin
                        state_n = C_IDLE;
                    end
                end else begin
                    if (tick)    ccnt_n    = ccnt_inc;
                    if (coin_ev) pending_n = 1'b1;
                end
            end
            default: begin
                state_n = C_IDLE;
                ccnt_n  = 8'd0;
            end
        endcase
    end

    assign credit_busy = (state != C_IDLE) | pending;

`ifdef INPUT_COND_AUTOFIRE_EN
    logic       af_ph;
    logic [7:0] af_cnt;
    logic [7:0] af_inc;

    assign af_inc = af_cnt + 8'd1;

    // Autofire phase: held at 1 while fire is released, toggles every AF_HALF ticks while held.
    always_ff @(posedge clk_sys) begin
        if (reset || !stb[4]) begin
            af_ph  <= 1'b1;
            af_cnt <= 8'd0;
        end else if (tick) begin
            if (af_inc == 8'(AF_HALF)) begin
                af_ph  <= ~af_ph;
                af_cnt <= 8'd0;
            end else begin
                af_cnt <= af_inc;
            end
        end
    end

    // Output word: debounced bits, gated fire, shaped coin.
    always_comb begin
        joy_out    = {coin_out, stb[6:0]};
        joy_out[4] = stb[4] & af_ph;
    end
`else
    logic unused_af;
    assign unused_af = (AF_HALF > 0);

    // Output word: debounced bits and shaped coin.
    always_comb begin
        joy_out = {coin_out, stb[6:0]};
    end
`endif
endmodule

// File: tb/tb_arcade_input_cond.sv
`timescale 1ns/1ps
module tb_arcade_input_cond;
    localparam int TD  = 4;
    localparam int AFH = 2;

    // Instance 0 uses the documented bench parameters; instance 1 uses a
    // one-tick debounce and long coin phases so credits can be queued.
    int deb_p [2] = '{3, 1};
    int chi_p [2] = '{2, 4};
    int clo_p [2] = '{2, 4};

    logic       clk_sys = 1'b0;
    logic       reset;
    logic [7:0] joy_in;
    logic [7:0] joy_out0, joy_out1;
    logic       busy0, busy1;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk_sys = ~clk_sys;

    arcade_input_cond #(.TICK_DIV(4), .DEB_LEN(3), .COIN_HI(2), .COIN_LO(2), .AF_HALF(2)) dut0 (
        .clk_sys(clk_sys), .reset(reset), .joy_in(joy_in), .joy_out(joy_out0), .credit_busy(busy0));
    arcade_input_cond #(.TICK_DIV(4), .DEB_LEN(1), .COIN_HI(4), .COIN_LO(4), .AF_HALF(2)) dut1 (
        .clk_sys(clk_sys), .reset(reset), .joy_in(joy_in), .joy_out(joy_out1), .credit_busy(busy1));

    // ---------------- reference model ----------------
    logic [7:0] s1, s2;
    int         ncyc    [2];
    logic [7:0] stable  [2];
    int         miss    [2][8];
    logic       prev7   [2];
    int         mode    [2];   // 0 idle, 1 pulse high, 2 gap
    int         tdone   [2];
    logic       pend    [2];
    logic       afph    [2];
    int         afcnt   [2];

    always @(posedge clk_sys) begin : model
        bit tk, ev;
        if (reset) begin
            s1 = 8'd0; s2 = 8'd0;
            for (int k = 0; k < 2; k++) begin
                ncyc[k] = 0; stable[k] = 8'd0; prev7[k] = 1'b0;
                mode[k] = 0; tdone[k] = 0; pend[k] = 1'b0;
                afph[k] = 1'b1; afcnt[k] = 0;
                for (int i = 0; i < 8; i++) miss[k][i] = 0;
            end
        end else begin
            for (int k = 0; k < 2; k++) begin
                tk = ((ncyc[k] % TD) == TD - 1);
                ncyc[k]++;
                ev = stable[k][7] && !prev7[k];
                prev7[k] = stable[k][7];
                if (!stable[k][4]) begin
                    afph[k] = 1'b1; afcnt[k] = 0;
                end else if (tk) begin
                    afcnt[k]++;
                    if (afcnt[k] == AFH) begin afph[k] = !afph[k]; afcnt[k] = 0; end
                end
                case (mode[k])
                    0: if (ev) begin mode[k] = 1; tdone[k] = 0; end
                    1: begin
                        if (ev) pend[k] = 1'b1;
                        if (tk) begin
                            tdone[k]++;
                            if (tdone[k] == chi_p[k]) begin mode[k] = 2; tdone[k] = 0; end
                        end
                    end
                    default: begin
                        if (tk && (tdone[k] + 1 == clo_p[k])) begin
                            tdone[k] = 0;
                            if (pend[k]) begin pend[k] = 1'b0; mode[k] = 1; end
                            else if (ev) mode[k] = 1;
                            else mode[k] = 0;
                        end else begin
                            if (tk) tdone[k]++;
                            if (ev) pend[k] = 1'b1;
                        end
                    end
                endcase
                for (int i = 0; i < 8; i++) begin
                    if (s2[i] == stable[k][i]) miss[k][i] = 0;
                    else if (tk) begin
                        miss[k][i]++;
                        if (miss[k][i] == deb_p[k]) begin stable[k][i] = s2[i]; miss[k][i] = 0; end
                    end
                end
            end
            s2 = s1;
            s1 = joy_in;
        end
    end

    function automatic logic [7:0] exp_out(input int k);
        logic [7:0] v;
        v = {(mode[k] == 1), stable[k][6:0]};
`ifdef INPUT_COND_AUTOFIRE_EN
        v[4] = stable[k][4] & afph[k];
`endif
        return v;
    endfunction

    function automatic logic exp_busy(input int k);
        return (mode[k] != 0) || pend[k];
    endfunction

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk_sys);
        chk("out0",  joy_out0, exp_out(0));
        chk("busy0", {7'd0, busy0}, {7'd0, exp_busy(0)});
        chk("out1",  joy_out1, exp_out(1));
        chk("busy1", {7'd0, busy1}, {7'd0, exp_busy(1)});
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin : stim
        int lat, w, pulses, gap, toggles, hold;
        logic got, seen, prev, rose;

        reset = 1'b1; joy_in = 8'd0;
        repeat (3) cyc();
        chk("reset_out", joy_out0, 8'd0);
        chk("reset_busy", {7'd0, busy0}, 8'd0);
        reset = 1'b0;
        repeat (5) cyc();

        // Clean press and release on bit 0
        joy_in = 8'h01; lat = 0; got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            if (!got && joy_out0[0]) begin got = 1'b1; lat = i + 1; end
        end
        chk("press_lat", {7'd0, got && (lat <= 15)}, 8'd1);
        joy_in = 8'h00; lat = 0; got = 1'b0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            if (!got && !joy_out0[0]) begin got = 1'b1; lat = i + 1; end
        end
        chk("release_lat", {7'd0, got && (lat <= 15)}, 8'd1);

        // Glitch on bit 1 shorter than two tick periods
        joy_in = 8'h02; seen = 1'b0;
        for (int i = 0; i < 26; i++) begin
            if (i == 6) joy_in = 8'h00;
            cyc();
            seen = seen | joy_out0[1];
        end
        chk("glitch", {7'd0, seen}, 8'd0);

        // Single coin held 20 cycles
        joy_in = 8'h80; pulses = 0; w = 0; prev = 1'b0;
        for (int i = 0; i < 70; i++) begin
            if (i == 20) joy_in = 8'h00;
            cyc();
            if (joy_out0[7] && !prev) begin pulses++; w = 0; end
            if (joy_out0[7]) w++;
            prev = joy_out0[7];
        end
        chk("coin_cnt", 8'(pulses), 8'd1);
        chk("coin_width", {7'd0, (w >= 5) && (w <= 8)}, 8'd1);
        chk("coin_idle_busy", {7'd0, busy0}, 8'd0);

        // Queued coins on instance 1: three edges, two pulses, gap of a full GAP phase
        pulses = 0; gap = 0; prev = 1'b0;
        for (int i = 0; i < 120; i++) begin
            joy_in = (i < 36 && (i % 12) < 6) ? 8'h80 : 8'h00;
            cyc();
            if (joy_out1[7] && !prev) pulses++;
            if (!joy_out1[7] && pulses == 1) gap++;
            prev = joy_out1[7];
        end
        chk("queue_cnt", 8'(pulses), 8'd2);
        chk("queue_gap", {7'd0, (gap >= 13) && (gap <= 16)}, 8'd1);
        chk("queue_idle", {7'd0, busy1}, 8'd0);

        // Reset in the middle of a coin pulse
        joy_in = 8'h80; seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            cyc();
            seen = joy_out0[7];
        end
        chk("rst_wait_hi", {7'd0, seen}, 8'd1);
        reset = 1'b1; joy_in = 8'h00;
        cyc();
        chk("rst_mid_out", joy_out0, 8'd0);
        chk("rst_mid_busy", {7'd0, busy0}, 8'd0);
        reset = 1'b0; seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            cyc();
            seen = seen | joy_out0[7];
        end
        chk("rst_no_pulse", {7'd0, seen}, 8'd0);

        // Fire held: autofire toggling or steady
        joy_in = 8'h10; toggles = 0; rose = 1'b0; prev = 1'b0;
        for (int i = 0; i < 60; i++) begin
            cyc();
            if (rose && joy_out0[4] != prev) toggles++;
            if (joy_out0[4]) rose = 1'b1;
            prev = joy_out0[4];
        end
        chk("af_rose", {7'd0, rose}, 8'd1);
`ifdef INPUT_COND_AUTOFIRE_EN
        chk("af_toggles", {7'd0, toggles >= 3}, 8'd1);
`else
        chk("af_steady", 8'(toggles), 8'd0);
`endif
        joy_in = 8'h00;
        repeat (30) cyc();

        // Random stimulus with occasional reset
        for (int s = 0; s < 40; s++) begin
            joy_in = 8'($urandom);
            hold = $urandom_range(1, 24);
            if ($urandom_range(0, 19) == 0) reset = 1'b1;
            for (int i = 0; i < hold; i++) begin
                cyc();
                reset = 1'b0;
            end
        end
        joy_in = 8'h00;
        repeat (60) cyc();
        chk("final_busy0", {7'd0, busy0}, 8'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
